// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: word/register widths, instruction field positions
// and the instruction class decode helper.
package cpu_pkg;

   localparam int WORD_DATA_W = 32;
   localparam int GPR_ADDR_W  = 5;

   typedef logic [WORD_DATA_W-1:0] word_data_t;
   typedef logic [GPR_ADDR_W-1:0]  gpr_addr_t;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RA_MSB  = 25;
   localparam int RA_LSB  = 21;
   localparam int RB_MSB  = 20;
   localparam int RB_LSB  = 16;
   localparam int RC_MSB  = 15;
   localparam int RC_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   // Register-file write enables are active-low throughout the pipeline.
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [1:0] {
      R_TYPE   = 2'b00,
      I_ALU    = 2'b01,
      LOAD     = 2'b10,
      STORE_BR = 2'b11
   } insn_class_t;

   function automatic insn_class_t insn_class(input logic [5:0] op);
      return insn_class_t'(op[5:4]);
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Register-file read bus: decode drives both read addresses, the register file
// returns WB-bypassed data combinationally.
interface gpr_rd_bus_io;
   import cpu_pkg::*;

   gpr_addr_t  addr_0;
   gpr_addr_t  addr_1;
   word_data_t data_0;
   word_data_t data_1;

   modport master (output addr_0, addr_1, input data_0, data_1);
   modport slave  (input addr_0, addr_1, output data_0, data_1);
endinterface

// File: rtl/id_hazard_fwd.sv
// Operand resolution and load-use hazard detection for the decode stage.
// ID_FWD_EN selects EX/MEM forwarding; without it any pending writer stalls.
module id_hazard_fwd
   import cpu_pkg::*;
(
   input  gpr_addr_t  ra_addr,
   input  gpr_addr_t  rb_addr,
   input  logic       ra_used,
   input  logic       rb_used,
   input  logic       if_en,
   input  word_data_t gpr_data_0,
   input  word_data_t gpr_data_1,
   input  logic       ex_en,
   input  gpr_addr_t  ex_dst_addr,
   input  logic       ex_gpr_we_,
   input  logic       ex_is_load,
   input  word_data_t ex_fwd_data,
   input  logic       mem_en,
   input  gpr_addr_t  mem_dst_addr,
   input  logic       mem_gpr_we_,
   input  word_data_t mem_fwd_data,
   output word_data_t ra_data,
   output word_data_t rb_data,
   output logic       ld_hazard
);

   logic       ex_wr;
   logic       mem_wr;
   gpr_addr_t  src_addr [2];
   word_data_t src_gpr  [2];
   word_data_t src_res  [2];
   logic [1:0] src_used;
   logic [1:0] ex_hit;
   logic [1:0] mem_hit;

   assign ex_wr    = ex_en  && (ex_gpr_we_  == ENABLE_);
   assign mem_wr   = mem_en && (mem_gpr_we_ == ENABLE_);
   assign src_addr[0] = ra_addr;
   assign src_addr[1] = rb_addr;
   assign src_gpr[0]  = gpr_data_0;
   assign src_gpr[1]  = gpr_data_1;
   assign src_used    = {rb_used, ra_used};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign ex_hit[gi]  = ex_wr  && (ex_dst_addr  == src_addr[gi]);
         assign mem_hit[gi] = mem_wr && (mem_dst_addr == src_addr[gi]);
`ifdef ID_FWD_EN
         // Youngest producer wins: EX result is newer than MEM result.
         assign src_res[gi] = ex_hit[gi]  ? ex_fwd_data  :
                              mem_hit[gi] ? mem_fwd_data : src_gpr[gi];
`else
         assign src_res[gi] = src_gpr[gi];
`endif
      end
   endgenerate

`ifdef ID_FWD_EN
   assign ld_hazard = if_en && ex_is_load && |(ex_hit & src_used);
`else
   logic unused_fwd;
   assign unused_fwd = ^{ex_fwd_data, mem_fwd_data, ex_is_load};
   assign ld_hazard  = if_en && |((ex_hit | mem_hit) & src_used);
`endif

   assign ra_data = src_res[0];
   assign rb_data = src_res[1];

endmodule

// File: rtl/id_stage.sv
// Decode stage: classifies the fetched instruction, resolves operands and
// loads the ID/EX register. Optional EX/MEM forwarding via ID_FWD_EN.
module id_stage
   import cpu_pkg::*;
#(
   parameter word_data_t RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  word_data_t        if_pc,
   input  word_data_t        if_insn,
   input  logic              if_en,
   input  logic              stall,
   input  logic              flush,
   gpr_rd_bus_io.master      gpr_rd,
   input  logic              ex_en,
   input  gpr_addr_t         ex_dst_addr,
   input  logic              ex_gpr_we_,
   input  logic              ex_is_load,
   input  word_data_t        ex_fwd_data,
   input  logic              mem_en,
   input  gpr_addr_t         mem_dst_addr,
   input  logic              mem_gpr_we_,
   input  word_data_t        mem_fwd_data,
   output logic              ld_hazard,
   output word_data_t        id_pc,
   output logic              id_en,
   output logic [5:0]        id_op,
   output word_data_t        id_ra_data,
   output word_data_t        id_rb_data,
   output word_data_t        id_imm,
   output gpr_addr_t         id_dst_addr,
   output logic              id_gpr_we_,
   output logic              id_is_load
);

   logic [5:0]  op;
   gpr_addr_t   ra_addr;
   gpr_addr_t   rb_addr;
   gpr_addr_t   rc_addr;
   logic [15:0] imm16;
   insn_class_t cls;

   gpr_addr_t   dst_next;
   logic        we_next;
   logic        is_load_next;
   logic        rb_used;
   word_data_t  imm_next;
   word_data_t  ra_next;
   word_data_t  rb_next;

   assign op      = if_insn[OP_MSB:OP_LSB];
   assign ra_addr = if_insn[RA_MSB:RA_LSB];
   assign rb_addr = if_insn[RB_MSB:RB_LSB];
   assign rc_addr = if_insn[RC_MSB:RC_LSB];
   assign imm16   = if_insn[IMM_MSB:IMM_LSB];
   assign cls     = insn_class(op);
   assign imm_next = {{16{imm16[15]}}, imm16};

   assign gpr_rd.addr_0 = ra_addr;
   assign gpr_rd.addr_1 = rb_addr;

   always_comb begin
      dst_next     = rc_addr;
      we_next      = ENABLE_;
      is_load_next = 1'b0;
      rb_used      = 1'b1;
      case (cls)
         R_TYPE: begin
            dst_next = rc_addr;
         end
         I_ALU: begin
            dst_next = rb_addr;
            rb_used  = 1'b0;
         end
         LOAD: begin
            dst_next     = rb_addr;
            is_load_next = 1'b1;
            rb_used      = 1'b0;
         end
         STORE_BR: begin
            dst_next = rb_addr;
            we_next  = DISABLE_;
         end
      endcase
   end

   id_hazard_fwd u_hazard_fwd (
      .ra_addr      (ra_addr),
      .rb_addr      (rb_addr),
      .ra_used      (1'b1),
      .rb_used      (rb_used),
      .if_en        (if_en),
      .gpr_data_0   (gpr_rd.data_0),
      .gpr_data_1   (gpr_rd.data_1),
      .ex_en        (ex_en),
      .ex_dst_addr  (ex_dst_addr),
      .ex_gpr_we_   (ex_gpr_we_),
      .ex_is_load   (ex_is_load),
      .ex_fwd_data  (ex_fwd_data),
      .mem_en       (mem_en),
      .mem_dst_addr (mem_dst_addr),
      .mem_gpr_we_  (mem_gpr_we_),
      .mem_fwd_data (mem_fwd_data),
      .ra_data      (ra_next),
      .rb_data      (rb_next),
      .ld_hazard    (ld_hazard)
   );

   // Flush outranks stall so a killed instruction never lingers in ID/EX.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_pc       <= RESET_PC;
         id_en       <= 1'b0;
         id_op       <= '0;
         id_ra_data  <= '0;
         id_rb_data  <= '0;
         id_imm      <= '0;
         id_dst_addr <= '0;
         id_gpr_we_  <= DISABLE_;
         id_is_load  <= 1'b0;
      end else if (flush) begin
         id_en      <= 1'b0;
         id_gpr_we_ <= DISABLE_;
      end else if (stall) begin
         id_en      <= id_en;
         id_gpr_we_ <= id_gpr_we_;
      end else if (ld_hazard) begin
         id_en      <= 1'b0;
         id_gpr_we_ <= DISABLE_;
      end else begin
         id_pc       <= if_pc;
         id_en       <= if_en;
         id_op       <= op;
         id_ra_data  <= ra_next;
         id_rb_data  <= rb_next;
         id_imm      <= imm_next;
         id_dst_addr <= dst_next;
         id_gpr_we_  <= if_en ? we_next : DISABLE_;
         id_is_load  <= is_load_next;
      end
   end

endmodule
